// File: rtl/display_owner_arb.sv
// display_owner_arb: frame-synchronous round-robin owner of the shared display.
// Ownership and display data change only on frame_tick edges, so a frame never tears.
// Optional build macro: DISP_ARB_BLANK_IDLE_EN (blank the display outputs when idle).
module display_owner_arb #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                  clk_video,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   seg_in,
  input  logic [16*N_REQ-1:0]   red_in,
  input  logic [16*N_REQ-1:0]   green_in,
  output logic [N_REQ-1:0]      grant,
  output logic                  owner_valid,
  output logic [ID_W-1:0]       owner_id,
  output logic [31:0]           segments,
  output logic [15:0]           red_leds,
  output logic [15:0]           green_leds
);

  localparam int unsigned     CNT_W  = 4;
  localparam int unsigned     IDX_W  = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
  localparam logic [ID_W-1:0]  RST_ID = ID_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_owner_id;
  logic [ID_W-1:0]    w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic               r_owner_valid;
  logic [31:0]        r_segments;
  logic [15:0]        r_red;
  logic [15:0]        r_green;
  logic [N_REQ-1:0]   w_own_mask;
  logic [N_REQ-1:0]   w_cand;
  logic               w_found;
  logic [ID_W-1:0]    w_pick;
  logic               w_load;
  logic               w_clear;
  logic [31:0]        w_seg_sel;
  logic [15:0]        w_red_sel;
  logic [15:0]        w_green_sel;

  // First set bit of cand searching from (last+1) mod N_REQ, wrapping; MSB = found.
  function automatic logic [ID_W:0] f_pick(input logic [N_REQ-1:0] cand,
                                           input logic [ID_W-1:0]  last);
    logic             found;
    logic [ID_W-1:0]  id;
    int unsigned      pos;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    id    = last;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = (32'(last) + k) % N_REQ;
      idx = IDX_W'(pos);
      if (!found && cand[idx]) begin
        found = 1'b1;
        id    = ID_W'(pos);
      end
    end
    return {found, id};
  endfunction

  // Next-state, owner, hold counter and data-load decisions (tick cycles only).
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner_id;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_own_mask  = N_REQ'(1) << r_owner_id;
    w_cand      = (r_state == ST_GRANTED) ? (req & ~w_own_mask) : req;
    {w_found, w_pick} = f_pick(w_cand, r_owner_id);
    if (frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            w_state_nxt = ST_GRANTED;
            w_owner_nxt = w_pick;
            w_cnt_nxt   = '0;
            w_load      = 1'b1;
          end
        end
        ST_GRANTED: begin
          if ((req & w_own_mask) == '0) begin
            if (w_found) begin
              w_owner_nxt = w_pick;
              w_cnt_nxt   = '0;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
`ifdef DISP_ARB_BLANK_IDLE_EN
              w_clear     = 1'b1;
`endif
            end
          end else if ((r_cnt >= HOLD_C) && w_found) begin
            w_owner_nxt = w_pick;
            w_cnt_nxt   = '0;
            w_load      = 1'b1;
          end else begin
            if (r_cnt < HOLD_C) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
            w_load = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_grant_nxt = (w_state_nxt == ST_GRANTED) ? (N_REQ'(1) << w_owner_nxt) : '0;
  end

  // Select the incoming owner's data slices.
  always_comb begin
    w_seg_sel   = '0;
    w_red_sel   = '0;
    w_green_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_owner_nxt == ID_W'(i)) begin
        w_seg_sel   = seg_in[32*i +: 32];
        w_red_sel   = red_in[16*i +: 16];
        w_green_sel = green_in[16*i +: 16];
      end
    end
  end

  // State, ownership and display shadow registers.
  always_ff @(posedge clk_video) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_owner_id    <= RST_ID;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_owner_valid <= 1'b0;
      r_segments    <= '0;
      r_red         <= '0;
      r_green       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner_id    <= w_owner_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_owner_valid <= (w_state_nxt == ST_GRANTED);
      if (w_load) begin
        r_segments <= w_seg_sel;
        r_red      <= w_red_sel;
        r_green    <= w_green_sel;
      end else if (w_clear) begin
        r_segments <= '0;
        r_red      <= '0;
        r_green    <= '0;
      end
    end
  end

  assign grant       = r_grant;
  assign owner_valid = r_owner_valid;
  assign owner_id    = r_owner_id;
  assign segments    = r_segments;
  assign red_leds    = r_red;
  assign green_leds  = r_green;

endmodule

// File: tb/tb_display_owner_arb.sv
// Bench for display_owner_arb: directed frames, a reference model of the
// ownership rules, and a per-cycle compare of every output.
module tb_display_owner_arb;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic          clk_video = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic [3:0]    req = '0;
  logic [127:0]  seg_in = '0;
  logic [63:0]   red_in = '0;
  logic [63:0]   green_in = '0;
  logic [3:0]    grant;
  logic          owner_valid;
  logic [1:0]    owner_id;
  logic [31:0]   segments;
  logic [15:0]   red_leds;
  logic [15:0]   green_leds;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_data = 1'b1;

  // Reference model state
  int          m_owner = N - 1;
  bit          m_valid = 1'b0;
  int          m_held  = 0;
  logic [31:0] m_seg   = '0;
  logic [15:0] m_red   = '0;
  logic [15:0] m_green = '0;

  display_owner_arb #(.N_REQ(4), .ID_W(2), .HOLD_FRAMES(8)) dut (
    .clk_video  (clk_video),
    .reset      (reset),
    .frame_tick (frame_tick),
    .req        (req),
    .seg_in     (seg_in),
    .red_in     (red_in),
    .green_in   (green_in),
    .grant      (grant),
    .owner_valid(owner_valid),
    .owner_id   (owner_id),
    .segments   (segments),
    .red_leds   (red_leds),
    .green_leds (green_leds)
  );

  always #5 clk_video = ~clk_video;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_take(input int n);
    m_owner = n;
    m_valid = 1'b1;
    m_held  = 0;
    m_seg   = seg_in[32*n +: 32];
    m_red   = red_in[16*n +: 16];
    m_green = green_in[16*n +: 16];
  endtask

  // Apply the ownership rules to the inputs sampled at this clock edge.
  task automatic model_edge();
    int nxt;
    int j;
    if (reset) begin
      m_owner = N - 1;
      m_valid = 1'b0;
      m_held  = 0;
      m_seg   = '0;
      m_red   = '0;
      m_green = '0;
      return;
    end
    if (!frame_tick) return;
    nxt = -1;
    for (int k = 1; k <= N; k++) begin
      j = (m_owner + k) % N;
      if (nxt < 0 && req[j] && !(m_valid && j == m_owner)) nxt = j;
    end
    if (!m_valid) begin
      if (nxt >= 0) model_take(nxt);
    end else if (!req[m_owner]) begin
      if (nxt >= 0) model_take(nxt);
      else begin
        m_valid = 1'b0;
`ifdef DISP_ARB_BLANK_IDLE_EN
        m_seg   = '0;
        m_red   = '0;
        m_green = '0;
`endif
      end
    end else if (m_held >= HOLD && nxt >= 0) begin
      model_take(nxt);
    end else begin
      if (m_held < HOLD) m_held++;
      model_take_keep();
    end
  endtask

  task automatic model_take_keep();
    m_seg   = seg_in[32*m_owner +: 32];
    m_red   = red_in[16*m_owner +: 16];
    m_green = green_in[16*m_owner +: 16];
  endtask

  task automatic compare();
    logic [3:0] eg;
    eg = m_valid ? (4'b0001 << m_owner) : 4'b0000;
    chk("grant",       32'(grant),       32'(eg));
    chk("owner_valid", 32'(owner_valid), 32'(m_valid));
    chk("owner_id",    32'(owner_id),    32'(m_owner));
    chk("segments",    segments,         m_seg);
    chk("red_leds",    32'(red_leds),    32'(m_red));
    chk("green_leds",  32'(green_leds),  32'(m_green));
  endtask

  // One clock: drive tick, update model at the edge, check 1 time unit later.
  task automatic step(input bit tk);
    frame_tick = tk;
    @(posedge clk_video);
    model_edge();
    #1;
    compare();
    frame_tick = 1'b0;
  endtask

  task automatic frame();
    repeat (3) step(1'b0);
    if (rnd_data) begin
      for (int i = 0; i < 4; i++) begin
        seg_in[32*i +: 32]   = $urandom;
        red_in[16*i +: 16]   = 16'($urandom);
        green_in[16*i +: 16] = 16'($urandom);
      end
    end
    step(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset state
    do_reset();
    chk("rst_owner_id", 32'(owner_id), 32'd3);
    chk("rst_grant",    32'(grant),    32'd0);

    // Single requester, data frozen between ticks
    rnd_data = 1'b0;
    req = 4'b0001;
    seg_in[31:0] = 32'h12345678;
    frame();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_seg",   segments,   32'h12345678);
    seg_in[31:0] = 32'hDEADBEEF;
    req = 4'b0010;
    repeat (3) step(1'b0);
    chk("frozen_seg",   segments,   32'h12345678);
    chk("frozen_grant", 32'(grant), 32'h1);
    req = 4'b0001;
    rnd_data = 1'b1;

    // Two continuous requesters, hold limit
    do_reset();
    req = 4'b0011;
    repeat (9) frame();
    chk("hold_t9", 32'(grant), 32'h1);
    frame();
    chk("hold_t10", 32'(grant), 32'h2);
    repeat (8) frame();
    chk("hold_t18", 32'(grant), 32'h2);
    frame();
    chk("hold_t19", 32'(grant), 32'h1);

    // Early release restarts the hold counter
    do_reset();
    req = 4'b0101;
    repeat (3) frame();
    req = 4'b0100;
    frame();
    chk("early_grant", 32'(grant),    32'h4);
    chk("early_id",    32'(owner_id), 32'd2);
    req = 4'b0101;
    repeat (8) frame();
    chk("early_hold8", 32'(grant), 32'h4);
    frame();
    chk("early_hold9", 32'(grant), 32'h1);

    // Round robin with each owner releasing after one frame
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      frame();
      chk("rr_order", 32'(grant), 32'(rr_exp[i]));
      req = 4'b1111 & ~rr_exp[i];
    end

    // Everyone drops: idle, owner_id keeps last owner
    req = 4'b0000;
    frame();
    chk("idle_valid", 32'(owner_valid), 32'd0);
    chk("idle_id",    32'(owner_id),    32'd0);
    repeat (2) frame();

    // Reset in a tick cycle while granted
    req = 4'b0001;
    frame();
    chk("pre_rst_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("tick_rst_id",    32'(owner_id), 32'd3);
    chk("tick_rst_grant", 32'(grant),    32'd0);
    chk("tick_rst_seg",   segments,      32'd0);
    req = 4'b1000;
    frame();
    chk("post_rst_grant", 32'(grant), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
